// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
//
// Takes a snapshot of N_INPUTS data lanes and sends it out on a valid/ready
// stream. A snapshot is accepted when in_valid && in_ready. What happens next
// depends on the mode sampled at that accept:
//   DIRECT (mode=0) : one beat carrying lane 'sel'. The beat has out_last=1.
//   SCAN   (mode=1) : N_INPUTS beats carrying lanes 0..N_INPUTS-1 in order.
//                     out_last is set on the final beat only.
// Every output is driven from a flop. A new transaction can start only after
// the block returns to IDLE, so there is one idle bubble between two
// transactions.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous reset, active high
//   in_array   lane data, N_INPUTS lanes of DATAWIDTH bits each
//   in_valid   snapshot request
//   in_ready   snapshot can be accepted (high only in IDLE)
//   mode       0 = DIRECT, 1 = SCAN (sampled on accept)
//   sel        lane select for DIRECT (sampled on accept)
//   out        beat data
//   out_idx    lane index of the current beat
//   out_valid  out / out_idx / out_last are valid
//   out_ready  downstream accepts the current beat
//   out_last   final beat of the transaction
// ---------------------------------------------------------------------------
module scan_mux #(
  parameter int DATAWIDTH = 16,
  parameter int N_INPUTS  = 8,
  parameter int SELWIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] in_array [N_INPUTS-1:0],
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [SELWIDTH-1:0]  sel,
  output logic [DATAWIDTH-1:0] out,
  output logic [SELWIDTH-1:0]  out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index of the final SCAN beat. The scan stops here even when
  // 2**SELWIDTH is larger than N_INPUTS.
  localparam logic [SELWIDTH-1:0] LAST_IDX = SELWIDTH'(N_INPUTS - 1);

  state_t               state_reg, state_next;
  logic [DATAWIDTH-1:0] out_reg, out_next;
  logic [SELWIDTH-1:0]  idx_reg, idx_next;
  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;

  // Snapshot buffer. SCAN beats are read only from this buffer, so
  // changes on in_array during DRAIN do not affect the output.
  logic [DATAWIDTH-1:0] snap_reg [N_INPUTS-1:0];
  logic                 snap_load;

  logic [SELWIDTH-1:0]  idx_inc;
  logic [DATAWIDTH-1:0] live_lane;  // in_array[sel], or 0 when sel is out of range
  logic [DATAWIDTH-1:0] next_lane;  // snap_reg[idx_reg + 1]
  logic                 xfer;

  assign idx_inc = idx_reg + SELWIDTH'(1);
  assign xfer    = valid_reg && out_ready;

  // Lane multiplexers. Each one compares against every legal lane index.
  // A select with no matching lane (sel >= N_INPUTS) gives zero and never
  // reads outside the array.
  always_comb begin
    live_lane = '0;
    next_lane = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel == SELWIDTH'(i)) begin
        live_lane = in_array[i];
      end
      if (idx_inc == SELWIDTH'(i)) begin
        next_lane = snap_reg[i];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    snap_load  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = DRAIN;
          valid_next = 1'b1;
          if (mode) begin
            // SCAN: lane 0 comes straight from the inputs on the same edge
            // that loads the buffer, so the first beat appears in the next
            // cycle. N_INPUTS >= 2, so the first beat is never the last.
            snap_load = 1'b1;
            out_next  = in_array[0];
            idx_next  = '0;
            last_next = 1'b0;
          end else begin
            out_next  = live_lane;
            idx_next  = sel;
            last_next = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (xfer) begin
          if (last_reg) begin
            // Leave out / out_idx as they are. Only the qualifiers drop.
            state_next = IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
          end else begin
            // Only SCAN reaches a non-final transfer.
            idx_next  = idx_inc;
            out_next  = next_lane;
            last_next = (idx_inc == LAST_IDX);
          end
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        last_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        snap_reg[i] <= '0;
      end
    end else if (snap_load) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        snap_reg[i] <= in_array[i];
      end
    end
  end

  // in_ready is decoded from the state flop only, so it has no
  // combinational path from out_ready.
  assign in_ready  = (state_reg == IDLE);
  assign out       = out_reg;
  assign out_idx   = idx_reg;
  assign out_valid = valid_reg;
  assign out_last  = last_reg;

endmodule

// File: tb/tb_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_scan_mux
//
// Directed testbench for scan_mux. The expected values are worked out by
// hand. Two instances are used: the default 8-lane one, and a 5-lane one
// whose SELWIDTH still allows index values up to 7.
// ---------------------------------------------------------------------------
module tb_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-lane instance
  logic [15:0] arr8 [7:0];
  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8, out_last8;
  logic [2:0]  sel8, idx8;
  logic [15:0] out8;

  // 5-lane instance
  logic [15:0] arr5 [4:0];
  logic        in_valid5, in_ready5, mode5, out_valid5, out_ready5, out_last5;
  logic [2:0]  sel5, idx5;
  logic [15:0] out5;

  int total = 0;
  int bad   = 0;

  scan_mux #(.DATAWIDTH(16), .N_INPUTS(8), .SELWIDTH(3)) dut8 (
    .clk(clk), .rst(rst), .in_array(arr8), .in_valid(in_valid8),
    .in_ready(in_ready8), .mode(mode8), .sel(sel8), .out(out8),
    .out_idx(idx8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_last(out_last8)
  );

  scan_mux #(.DATAWIDTH(16), .N_INPUTS(5), .SELWIDTH(3)) dut5 (
    .clk(clk), .rst(rst), .in_array(arr5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out(out5),
    .out_idx(idx5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_last(out_last5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then 1 time unit more. Outputs are
  // sampled and inputs are driven at that point, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat8(input string tag, input logic [15:0] d,
                             input logic [2:0] i, input logic l);
    check({tag, ".valid"}, {31'd0, out_valid8}, 32'd1);
    check({tag, ".out"},   {16'd0, out8},       {16'd0, d});
    check({tag, ".idx"},   {29'd0, idx8},       {29'd0, i});
    check({tag, ".last"},  {31'd0, out_last8},  {31'd0, l});
    check({tag, ".rdy"},   {31'd0, in_ready8},  32'd0);
  endtask

  task automatic check_beat5(input string tag, input logic [15:0] d,
                             input logic [2:0] i, input logic l);
    check({tag, ".valid"}, {31'd0, out_valid5}, 32'd1);
    check({tag, ".out"},   {16'd0, out5},       {16'd0, d});
    check({tag, ".idx"},   {29'd0, idx5},       {29'd0, i});
    check({tag, ".last"},  {31'd0, out_last5},  {31'd0, l});
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid8 = 0; mode8 = 0; sel8 = 0; out_ready8 = 0;
    in_valid5 = 0; mode5 = 0; sel5 = 0; out_ready5 = 1;
    for (int i = 0; i < 8; i++) arr8[i] = 16'hFFFF;
    for (int i = 0; i < 5; i++) arr5[i] = 16'hFFFF;

    // 1: reset held for 2 cycles, then released
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst.in_ready", {31'd0, in_ready8}, 32'd1);
    check("rst.valid",    {31'd0, out_valid8}, 32'd0);
    check("rst.out",      {16'd0, out8}, 32'd0);
    check("rst.idx",      {29'd0, idx8}, 32'd0);
    check("rst.last",     {31'd0, out_last8}, 32'd0);
    $display("txn reset done");

    // 2: DIRECT, sel=5
    for (int i = 0; i < 8; i++) arr8[i] = 16'h0A00 + 16'(i);
    mode8 = 0; sel8 = 3'd5; in_valid8 = 1; out_ready8 = 1;
    tick();
    in_valid8 = 0;
    check_beat8("direct5", 16'h0A05, 3'd5, 1'b1);
    tick();
    check("direct5.post_valid", {31'd0, out_valid8}, 32'd0);
    check("direct5.post_rdy",   {31'd0, in_ready8}, 32'd1);
    check("direct5.post_out",   {16'd0, out8}, 32'h0A05);
    check("direct5.post_last",  {31'd0, out_last8}, 32'd0);
    $display("txn direct sel=5");

    // DIRECT with the top legal index
    sel8 = 3'd7; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    check_beat8("direct7", 16'h0A07, 3'd7, 1'b1);
    tick();
    $display("txn direct sel=7");

    // 3: SCAN, out_ready held high. in_array is overwritten during the drain
    // and must not change the beats.
    for (int i = 0; i < 8; i++) arr8[i] = 16'(i * 3);
    mode8 = 1; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    for (int i = 0; i < 8; i++) arr8[i] = 16'hBEEF;
    for (int b = 0; b < 8; b++) begin
      check_beat8($sformatf("scan.b%0d", b), 16'(b * 3), 3'(b), b == 7);
      tick();
    end
    check("scan.end_valid", {31'd0, out_valid8}, 32'd0);
    check("scan.end_rdy",   {31'd0, in_ready8}, 32'd1);
    $display("txn scan 8 beats");

    // 4: SCAN with out_ready going 1,0,0,1,0,0,... and in_valid pulsed
    // during the drain
    for (int i = 0; i < 8; i++) arr8[i] = 16'h1000 + 16'(i * 7);
    mode8 = 1; in_valid8 = 1; out_ready8 = 0;
    tick();
    for (int i = 0; i < 8; i++) arr8[i] = 16'hDEAD;
    sel8 = 3'd2; mode8 = 0;
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      check_beat8($sformatf("stall.c%0d", c), 16'h1000 + 16'(k * 7), 3'(k), k == 7);
      out_ready8 = (c % 3 == 0);
      in_valid8  = (k < 7);
      tick();
      if (out_ready8) k++;
    end
    check("stall.beats", k, 8);
    in_valid8 = 0; out_ready8 = 1;
    check("stall.end_valid", {31'd0, out_valid8}, 32'd0);
    check("stall.end_rdy",   {31'd0, in_ready8}, 32'd1);
    $display("txn scan with stalls");

    // 6: reset while a SCAN is in progress, after 3 beats have transferred
    for (int i = 0; i < 8; i++) arr8[i] = 16'h2000 + 16'(i);
    mode8 = 1; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    tick(); tick(); tick();
    check_beat8("abort.pre", 16'h2003, 3'd3, 1'b0);
    rst = 1'b1;
    tick();
    check("abort.valid", {31'd0, out_valid8}, 32'd0);
    check("abort.out",   {16'd0, out8}, 32'd0);
    check("abort.idx",   {29'd0, idx8}, 32'd0);
    check("abort.rdy",   {31'd0, in_ready8}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort.idle_valid", {31'd0, out_valid8}, 32'd0);
    for (int i = 0; i < 8; i++) arr8[i] = 16'h3000 + 16'(i);
    mode8 = 1; in_valid8 = 1;
    tick();
    in_valid8 = 0;
    check_beat8("renew.b0", 16'h3000, 3'd0, 1'b0);
    tick();
    check_beat8("renew.b1", 16'h3001, 3'd1, 1'b0);
    $display("txn reset abort and restart");

    // 5: 5-lane instance, SCAN and out-of-range DIRECT
    for (int i = 0; i < 5; i++) arr5[i] = 16'h0050 + 16'(i);
    mode5 = 1; in_valid5 = 1;
    tick();
    in_valid5 = 0;
    for (int b = 0; b < 5; b++) begin
      check_beat5($sformatf("n5scan.b%0d", b), 16'h0050 + 16'(b), 3'(b), b == 4);
      tick();
    end
    check("n5scan.end_valid", {31'd0, out_valid5}, 32'd0);
    $display("txn n5 scan 5 beats");

    mode5 = 0; sel5 = 3'd6; in_valid5 = 1;
    tick();
    in_valid5 = 0;
    check_beat5("n5direct6", 16'h0000, 3'd6, 1'b1);
    tick();
    check("n5direct6.post_valid", {31'd0, out_valid5}, 32'd0);
    $display("txn n5 direct sel=6");

    mode5 = 0; sel5 = 3'd4; in_valid5 = 1;
    tick();
    in_valid5 = 0;
    check_beat5("n5direct4", 16'h0054, 3'd4, 1'b1);
    tick();
    $display("txn n5 direct sel=4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
